// File: rtl/fetch_issue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_issue
//  Description : Instruction-fetch sequencer. Boots from the reset-vector
//                word, then streams sequential instruction words into a small
//                in-order queue that decode drains with valid/ready. A PC
//                redirect flushes the queue and drops any in-flight read.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_issue #(
    parameter int          DEPTH          = 4,
    parameter logic [31:0] RESET_VEC_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    input  logic        inst_ready_i,
    output logic [31:0] pc_o,
    output logic        busy_o
);

    localparam int            AW        = $clog2(DEPTH);
    localparam int            CW        = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [31:0]   BOOT_ADDR = RESET_VEC_ADDR & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        BOOT_REQ   = 2'd0,
        BOOT_WAIT  = 2'd1,
        FETCH_REQ  = 2'd2,
        FETCH_WAIT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic          mem_req_q, mem_req_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic          discard_q, discard_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   fifo_inst_q [DEPTH];
    logic [31:0]   fifo_pc_q   [DEPTH];

    logic          ack;
    logic          valid;
    logic          push;
    logic          pop;
    logic          flush;
    logic [31:0]   redirect_target;

    // An ack only counts against an outstanding request
    assign ack             = mem_req_q && mem_ack_i;
    assign valid           = (count_q != '0);
    assign redirect_target = redirect_pc_i & 32'hFFFF_FFFC;

    // Sequencer: boot read, fetch issue/complete, redirect handling
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        discard_d  = discard_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            BOOT_REQ: begin
                mem_req_d  = 1'b1;
                mem_addr_d = BOOT_ADDR;
                state_d    = BOOT_WAIT;
            end
            BOOT_WAIT: begin
                if (ack) begin
                    mem_req_d = 1'b0;
                    pc_d      = mem_data_i & 32'hFFFF_FFFC;
                    state_d   = FETCH_REQ;
                end
            end
            FETCH_REQ: begin
                if (redirect_i) begin
                    // Issue nothing this cycle so the next request uses the new PC
                    flush = 1'b1;
                    pc_d  = redirect_target;
                end else if (count_q < DEPTH_C) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc_q;
                    state_d    = FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (ack) begin
                    mem_req_d = 1'b0;
                    discard_d = 1'b0;
                    state_d   = FETCH_REQ;
                    if (!redirect_i && !discard_q) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end
                if (redirect_i) begin
                    // The held request keeps its address; its data is dropped on ack
                    flush = 1'b1;
                    pc_d  = redirect_target;
                    if (!ack) begin
                        discard_d = 1'b1;
                    end
                end
            end
            default: state_d = BOOT_REQ;
        endcase
    end

    // Queue pointers and occupancy; a flush overrides push and pop
    always_comb begin
        pop    = valid && inst_ready_i && !flush;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wptr_d = wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_d = rptr_q + AW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // Control and bookkeeping registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= BOOT_REQ;
            pc_q       <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            discard_q  <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            discard_q  <= discard_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage; stale slots are never visible because the head is masked by count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst_q[wptr_q] <= mem_data_i;
            fifo_pc_q[wptr_q]   <= pc_q;
        end
    end

    assign mem_req_o    = mem_req_q;
    assign mem_addr_o   = mem_addr_q;
    assign inst_valid_o = valid;
    assign inst_o       = valid ? fifo_inst_q[rptr_q] : 32'd0;
    assign inst_pc_o    = valid ? fifo_pc_q[rptr_q]   : 32'd0;
    assign pc_o         = pc_q;
    assign busy_o       = (state_q == BOOT_REQ) || (state_q == BOOT_WAIT);

endmodule
`default_nettype wire
